// File: rtl/multi_debouncer_pkg.sv
// rtl/multi_debouncer_pkg.sv - shared types and defaults for the multi-channel debouncer
// Purpose: per-channel FSM state encoding and the default stability window.
// Ports: none (package).
package multi_debouncer_pkg;

  typedef enum logic [1:0] {
    STABLE_LOW  = 2'd0,
    RISE_WAIT   = 2'd1,
    STABLE_HIGH = 2'd2,
    FALL_WAIT   = 2'd3
  } db_state_e;

  // 20 ms at 48 MHz
  localparam int unsigned DEFAULT_STABLE_CYCLES = 960000;

endpackage

// File: rtl/multi_debouncer_if.sv
// rtl/multi_debouncer_if.sv - event valid/ready handshake toward the keypad decoder
// Purpose: bundles the debounced-edge event stream.
// Signals: event_valid (event presented), event_ready (consumer accepts),
//          event_ch (channel index), event_press (1 = press, 0 = release).
// Modports: master (debouncer side), slave (consumer side).
interface multi_debouncer_if #(
  parameter int CH_W = 2
);
  logic            event_valid;
  logic            event_ready;
  logic [CH_W-1:0] event_ch;
  logic            event_press;

  modport master (output event_valid, output event_ch, output event_press, input event_ready);
  modport slave  (input event_valid, input event_ch, input event_press, output event_ready);
endinterface

// File: rtl/multi_debouncer_channel.sv
// rtl/multi_debouncer_channel.sv - one channel: optional synchroniser, stability counter, FSM
// Purpose: debounces a single raw input into a clean level and edge-post strobes.
// Config macro: DEBOUNCE_SYNC_EN adds a 2-flop synchroniser in front of the FSM.
// Ports: clk, reset (async active-low), sig_i (raw input), level_o (debounced level),
//        post_o (one-cycle strobe on a confirmed edge), press_o (edge type, valid with post_o).
module debounce_channel
  import multi_debouncer_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
  parameter int unsigned CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic sig_i,
  output logic level_o,
  output logic post_o,
  output logic press_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic s;

`ifdef DEBOUNCE_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sync_q <= '0;
    else        sync_q <= {sync_q[0], sig_i};
  end

  assign s = sync_q[1];
`else
  assign s = sig_i;
`endif

  db_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;

  // Saturating increment: the counter must never wrap back into range
  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= STABLE_LOW;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    post_o  = 1'b0;
    press_o = 1'b0;
    case (state_q)
      STABLE_LOW: begin
        if (s) begin
          state_d = RISE_WAIT;
          cnt_d   = CNT_W'(1);
        end
      end
      RISE_WAIT: begin
        if (!s) begin
          state_d = STABLE_LOW;
          cnt_d   = '0;
        end else if (cnt_q >= CNT_LAST) begin
          state_d = STABLE_HIGH;
          cnt_d   = '0;
          post_o  = 1'b1;
          press_o = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      STABLE_HIGH: begin
        if (!s) begin
          state_d = FALL_WAIT;
          cnt_d   = CNT_W'(1);
        end
      end
      FALL_WAIT: begin
        if (s) begin
          state_d = STABLE_HIGH;
          cnt_d   = '0;
        end else if (cnt_q >= CNT_LAST) begin
          state_d = STABLE_LOW;
          cnt_d   = '0;
          post_o  = 1'b1;
          press_o = 1'b0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = STABLE_LOW;
        cnt_d   = '0;
      end
    endcase
  end

  // Level follows the FSM: high while confirmed high or still waiting to confirm a fall
  assign level_o = (state_q == STABLE_HIGH) || (state_q == FALL_WAIT);

endmodule

// File: rtl/multi_debouncer.sv
// rtl/multi_debouncer.sv - N-channel debouncer with per-channel event slots and handshake output
// Purpose: debounces N_CH inputs and queues confirmed press/release edges to a 1-entry output stage.
// Config macro: DEBOUNCE_SYNC_EN (forwarded to every channel; adds a 2-flop synchroniser).
// Ports: clk, reset (async active-low), sig_in (raw inputs), sig_out (debounced levels),
//        ev (event handshake, master side), overrun (sticky per-channel overwrite flags),
//        overrun_clr (clears all overrun bits).
module multi_debouncer
  import multi_debouncer_pkg::*;
#(
  parameter int unsigned N_CH          = 4,
  parameter int unsigned STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
  parameter int unsigned CNT_W         = $clog2(STABLE_CYCLES + 1),
  parameter int unsigned CH_W          = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_CH-1:0]       sig_in,
  output logic [N_CH-1:0]       sig_out,
  multi_debouncer_if.master     ev,
  output logic [N_CH-1:0]       overrun,
  input  logic                  overrun_clr
);

  logic [N_CH-1:0] post;
  logic [N_CH-1:0] chan_press;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    debounce_channel #(
      .STABLE_CYCLES (STABLE_CYCLES),
      .CNT_W         (CNT_W)
    ) u_ch (
      .clk     (clk),
      .reset   (reset),
      .sig_i   (sig_in[g]),
      .level_o (sig_out[g]),
      .post_o  (post[g]),
      .press_o (chan_press[g])
    );
  end

  // Pending slots, output register, overrun flags
  logic [N_CH-1:0] full_q, full_d;
  logic [N_CH-1:0] spress_q, spress_d;
  logic [N_CH-1:0] overrun_q, overrun_d;
  logic            valid_q, valid_d;
  logic [CH_W-1:0] ch_q, ch_d;
  logic            opress_q, opress_d;

  logic            pick_found;
  logic [CH_W-1:0] pick_idx;
  logic            load_en;
  logic [N_CH-1:0] take_vec;
  logic [N_CH-1:0] ovr_set;

  // Lowest-index full slot wins: scan downward so the last hit is the lowest index
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (full_q[i]) begin
        pick_found = 1'b1;
        pick_idx   = CH_W'(i);
      end
    end
  end

  assign load_en = !valid_q || ev.event_ready;

  always_comb begin
    take_vec = '0;
    full_d   = full_q;
    spress_d = spress_q;
    ovr_set  = '0;
    for (int i = 0; i < N_CH; i++) begin
      take_vec[i] = load_en && pick_found && (pick_idx == CH_W'(i));
      // A simultaneous take drains the old entry, so the new post lands in a free slot
      if (post[i]) begin
        full_d[i]   = 1'b1;
        spress_d[i] = chan_press[i];
        ovr_set[i]  = full_q[i] && !take_vec[i];
      end else if (take_vec[i]) begin
        full_d[i] = 1'b0;
      end
    end
    // A new overrun wins over a clear on the same edge
    overrun_d = (overrun_clr ? '0 : overrun_q) | ovr_set;
  end

  always_comb begin
    valid_d  = valid_q;
    ch_d     = ch_q;
    opress_d = opress_q;
    if (load_en) begin
      valid_d = pick_found;
      if (pick_found) begin
        ch_d     = pick_idx;
        opress_d = spress_q[pick_idx];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      full_q    <= '0;
      spress_q  <= '0;
      overrun_q <= '0;
      valid_q   <= 1'b0;
      ch_q      <= '0;
      opress_q  <= 1'b0;
    end else begin
      full_q    <= full_d;
      spress_q  <= spress_d;
      overrun_q <= overrun_d;
      valid_q   <= valid_d;
      ch_q      <= ch_d;
      opress_q  <= opress_d;
    end
  end

  assign ev.event_valid = valid_q;
  assign ev.event_ch    = ch_q;
  assign ev.event_press = opress_q;
  assign overrun        = overrun_q;

endmodule
